// File: rtl/alu_tv_pkg.sv
// Shared types and constants for the on-board alu test-vector checker.
// Tuple layout, FSM states, alu opcodes and flag bit positions live here.
package alu_tv_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [1:0]  pad;
    logic [1:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [3:0]  flags;
  } alu_tv_t;

  localparam int TV_W = $bits(alu_tv_t);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;

endpackage

// File: rtl/chk_delay_line.sv
// Fixed-latency shift register with a valid bit per stage; it carries the
// expected result of each accepted tuple until the alu answer is due.
module chk_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid
);

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else begin
      valid[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) valid[i] <= valid[i-1];
    end
  end

  // NOTE: payload stages are not reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    data[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) data[i] <= data[i-1];
  end

  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign any_valid = |valid;

endmodule

// File: rtl/alu_vector_checker.sv
// Streams test-vector tuples into an alu, compares its answers against the
// expected fields and keeps saturating pass/fail counts plus the first failure.
module alu_vector_checker
  import alu_tv_pkg::*;
#(
  parameter int VEC_W   = 104,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = 10,
  parameter int DUT_LAT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [VEC_W-1:0] vec_data,
  input  logic             vec_last,
  output logic [31:0]      a,
  output logic [31:0]      b,
  output logic [1:0]       ALUControl,
  input  logic [31:0]      dut_result,
  input  logic [3:0]       dut_flags,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [IDX_W-1:0] first_fail_idx
);

  localparam int EXP_W = 32 + 4 + IDX_W;

  chk_state_t       state;
  alu_tv_t          tv;
  logic             accept;
  logic             clear;
  logic             retire;
  logic             fail;
  logic             pipe_busy;
  logic [IDX_W-1:0] idx;
  logic [EXP_W-1:0] exp_in;
  logic [EXP_W-1:0] exp_out;
  logic [31:0]      exp_result;
  logic [3:0]       exp_flags;
  logic [IDX_W-1:0] exp_idx;
  logic             unused_pad;

  assign tv         = vec_data[TV_W-1:0];
  assign unused_pad = ^tv.pad;

  assign vec_ready = (state == RUN);
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign accept    = vec_valid & vec_ready;
  assign clear     = start & ((state == IDLE) || (state == DONE));

  assign exp_in = {tv.result, tv.flags, idx};
  assign {exp_result, exp_flags, exp_idx} = exp_out;
  assign fail   = (dut_result != exp_result) || (dut_flags != exp_flags);

  chk_delay_line #(
    .DEPTH (DUT_LAT + 1),
    .WIDTH (EXP_W)
  ) u_exp_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_data   (exp_in),
    .out_valid (retire),
    .out_data  (exp_out),
    .any_valid (pipe_busy)
  );

  // NOTE: every register below uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      a                <= '0;
      b                <= '0;
      ALUControl       <= '0;
      idx              <= '0;
      mismatch         <= 1'b0;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else begin
      mismatch <= 1'b0;

      case (state)
        IDLE, DONE: if (start) state <= RUN;
        RUN:        if (accept && vec_last) state <= DRAIN;
        DRAIN:      if (!pipe_busy) state <= DONE;
        default:    state <= IDLE;
      endcase

      // The pipe is always empty in IDLE/DONE, so clear and retire never overlap.
      if (clear) begin
        idx              <= '0;
        pass_count       <= '0;
        fail_count       <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx   <= '0;
      end else if (retire) begin
        if (fail) begin
          mismatch <= 1'b1;
          if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= exp_idx;
          end
        end else if (pass_count != '1) begin
          pass_count <= pass_count + CNT_W'(1);
        end
      end

      if (accept) begin
        a          <= tv.a;
        b          <= tv.b;
        ALUControl <= tv.ctrl;
        idx        <= idx + IDX_W'(1);
      end
    end
  end

endmodule
